// File: rtl/rv32i_imem_arbiter.sv
// Instruction-memory arbiter: shares a single-ported memory between fetch reads
// and loader writes, sequencing two-beat writes and phase-checked reads.
module rv32i_imem_arbiter #(
  parameter int unsigned MEM_WORDS  = 128,
  parameter int unsigned RD_TIMEOUT = 7,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  output logic        o_fetch_ack,
  output logic [31:0] o_fetch_data,
  input  logic        i_load_req,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data,
  output logic        o_load_ack,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_wr_addr,
  output logic [31:0] o_mem_wr_data,
  input  logic        i_mem_wr_valid,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_rd_addr,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_rd_valid,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned WORD_W = 30;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD, RESP} state_t;

  state_t             state, state_nx;
  logic               served_load, served_load_nx;
  logic               last_load, last_load_nx;
  logic [WORD_W-1:0]  word_q, word_nx;
  logic [31:0]        wdata_q, wdata_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        fdata_nx;
  logic               err_nx;
  logic               fetch_elig, load_elig, pick_load;
  logic [31:0]        grant_addr;
  logic               wr_en_nx, rd_en_nx, fack_nx, lack_nx, busy_nx;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{i_fetch_addr[1:0], i_load_addr[1:0]};

  // Address/data outputs come straight from the grant-time latches.
  assign o_mem_wr_addr = {word_q, 2'b00};
  assign o_mem_rd_addr = {word_q, 2'b00};
  assign o_mem_wr_data = wdata_q;

  // State register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      served_load  <= 1'b0;
      last_load    <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      o_fetch_data <= '0;
      o_err        <= 1'b0;
      o_fetch_ack  <= 1'b0;
      o_load_ack   <= 1'b0;
      o_mem_wr_en  <= 1'b0;
      o_mem_rd_en  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_nx;
      served_load  <= served_load_nx;
      last_load    <= last_load_nx;
      word_q       <= word_nx;
      wdata_q      <= wdata_nx;
      cnt          <= cnt_nx;
      o_fetch_data <= fdata_nx;
      o_err        <= err_nx;
      o_fetch_ack  <= fack_nx;
      o_load_ack   <= lack_nx;
      o_mem_wr_en  <= wr_en_nx;
      o_mem_rd_en  <= rd_en_nx;
      o_busy       <= busy_nx;
    end
  end

  // Next-state, grant arbitration and next values of the registered outputs.
  always_comb begin
    state_nx       = state;
    served_load_nx = served_load;
    last_load_nx   = last_load;
    word_nx        = word_q;
    wdata_nx       = wdata_q;
    cnt_nx         = cnt;
    fdata_nx       = o_fetch_data;
    err_nx         = o_err;
    fetch_elig     = i_fetch_req && !o_fetch_ack;
    load_elig      = i_load_req && !o_load_ack;
    pick_load      = load_elig && (!fetch_elig || !last_load);
    grant_addr     = pick_load ? i_load_addr : i_fetch_addr;

    case (state)
      IDLE: begin
        if (fetch_elig || load_elig) begin
          served_load_nx = pick_load;
          word_nx        = grant_addr[31:2];
          cnt_nx         = '0;
          if (pick_load) wdata_nx = i_load_data;
          if (grant_addr[31:2] >= WORD_W'(MEM_WORDS)) begin
            err_nx   = 1'b1;
            state_nx = RESP;
            if (!pick_load) fdata_nx = NOP_WORD;
          end else begin
            state_nx = pick_load ? WR_LO : RD;
          end
        end
      end
      WR_LO: begin
        if (i_mem_wr_valid) err_nx = 1'b1;
        state_nx = WR_HI;
      end
      WR_HI: begin
        if (!i_mem_wr_valid) err_nx = 1'b1;
        state_nx = RESP;
      end
      RD: begin
        cnt_nx = cnt + CNT_W'(1);
        // A valid seen before counter 2 belongs to a phase started on a stale address.
        if (i_mem_rd_valid && (cnt >= CNT_W'(2))) begin
          fdata_nx = i_mem_rd_data;
          state_nx = RESP;
        end else if (cnt >= CNT_W'(RD_TIMEOUT)) begin
          fdata_nx = NOP_WORD;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        last_load_nx = served_load;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    wr_en_nx = (state_nx == WR_LO) || (state_nx == WR_HI);
    rd_en_nx = (state_nx == RD);
    fack_nx  = (state_nx == RESP) && !served_load_nx;
    lack_nx  = (state_nx == RESP) && served_load_nx;
    busy_nx  = (state_nx != IDLE);
  end

endmodule
